command_sender: RTL and testbench
=================================

// Module: command_sender
// PURPOSE
//  Consumes {start, command_1[2:0]} from the link sequencer; returns ready_command.
//  Expands the 3-bit command index into a fixed ASCII byte string from an internal ROM.
//  Streams those bytes one at a time to the UART transmitter via tx_start/tx_busy.
//  ready_command high = idle, able to accept a command; low = string in progress.
// PARAMETERS
//  GAP_CYCLES    16'd100  idle clocks inserted after each byte's tx_busy falls (0 = none)
//  BUSY_TIMEOUT  16'd1000 max clocks to wait for tx_busy to rise after tx_start
// PORTS
//  clk            in   1  system clock, all logic on posedge
//  rst            in   1  asynchronous, active-low reset
//  start          in   1  level request from sequencer; rising edge launches a command
//  command_1      in   3  command index, sampled on the start rising edge only
//  ready_command  out  1  1 = idle; 0 = busy sending
//  tx_data        out  8  byte to UART TX; valid while tx_start=1, held until next load
//  tx_start       out  1  one-clock pulse requesting transmission of tx_data
//  tx_busy        in   1  UART TX busy flag: rises after tx_start, falls when byte sent
//  cmd_err        out  1  sticky: tx_busy timeout or invalid index; cleared on next launch
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, ready_command=1, tx_start=0, tx_data=8'h00,
//   cmd_err=0, byte index=0, counters=0, start edge register=0.
//  ROM (index: bytes, length):
//   0: "AT\r\n"      41 54 0D 0A              len 4
//   1: "ATE0\r\n"    41 54 45 30 0D 0A        len 6
//   2: "AT+RST\r\n"  41 54 2B 52 53 54 0D 0A  len 8
//   3: "AT+GMR\r\n"  41 54 2B 47 4D 52 0D 0A  len 8
//   4-7: len 0 (invalid)
//  Start detect: start_q registered each clk; launch = start & ~start_q. start held high
//   does not relaunch; a new rising edge is required.
//  FSM:
//   IDLE    ready_command=1. On launch: latch command_1, idx=0, cmd_err=0,
//           ready_command=0 next clk, go LOAD.
//   LOAD    If len==0: cmd_err=1, go FINISH. Else tx_data=ROM[cmd][idx],
//           tx_start=1 for exactly this one clk, clear timer, go WAIT_HI.
//   WAIT_HI tx_busy=1 -> WAIT_LO. Else timer++; if timer reaches BUSY_TIMEOUT,
//           cmd_err=1, go FINISH (abort rest of string).
//   WAIT_LO tx_busy=0 -> clear timer, go GAP.
//   GAP     Count GAP_CYCLES clocks (skip if 0). Then if idx==len-1 go FINISH,
//           else idx++ and go LOAD.
//   FINISH  ready_command=1 next clk, go IDLE.
//   Illegal state encodings -> IDLE with reset output values.
//  Latency: launch edge -> first tx_start = 2 clocks (IDLE->LOAD->pulse).
//  ready_command falls the clock after launch and stays low at least 2 clocks,
//   so the sequencer always observes the 1->0->1 sequence.
//  start dropping mid-string is ignored; the string always completes or times out.
//  Launch edge while busy is ignored (not queued).
//  command_1 changes while busy have no effect (latched copy used).
//  Counters: 16-bit, saturate, never wrap. idx is 3 bits; max len 8 -> idx 0..7.
//  Async reset mid-string: immediate return to reset values. A partial string is
//   acceptable; the byte already inside the UART is not recalled.
// TESTING
//  1 Reset, idle: ready_command=1, tx_start=0, cmd_err=0; tx_busy toggling -> no tx_start.
//  2 cmd 0, TX model busy 10 clks, GAP_CYCLES=4:
//    exactly 4 tx_start pulses with 41,54,0D,0A; ready_command low->high once; cmd_err=0.
//  3 Full sequencer flow: cmds 0,1,2,3 in turn -> 4+6+8+8 = 26 bytes in ROM order, no extras.
//  4 cmd 5: no tx_start; ready_command low 2 clks then high; cmd_err=1;
//    next valid launch clears cmd_err.
//  5 tx_busy stuck 0, BUSY_TIMEOUT=20: one tx_start then ~20 clks later cmd_err=1,
//    ready_command=1.
//  6 rst=0 during byte 3 of cmd 2: outputs go to reset values at once;
//    after release a new launch of cmd 2 restarts at byte 41.

Source files
------------

// File: rtl/command_sender.sv
// ============================================================================
// Module  : command_sender
// Brief   : Expands a 3-bit command index into a ROM byte string and streams
//           it to a UART transmitter through a tx_start / tx_busy handshake.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module command_sender #(
    parameter logic [15:0] GAP_CYCLES   = 16'd100,
    parameter logic [15:0] BUSY_TIMEOUT = 16'd1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] command_1,
    output logic       ready_command,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       cmd_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_GAP     = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    state_t      r_state;
    logic        r_start_q;
    logic [2:0]  r_cmd;
    logic [2:0]  r_idx;
    logic [15:0] r_timer;
    logic        r_ready;
    logic [7:0]  r_tx_data;
    logic        r_tx_start;
    logic        r_err;

    logic        w_launch;
    logic [3:0]  w_len;
    logic [7:0]  w_byte;
    logic        w_last;
    logic [15:0] w_timer_inc;

    assign w_launch    = start & ~r_start_q;
    assign w_last      = ({1'b0, r_idx} == (w_len - 4'd1));
    assign w_timer_inc = (r_timer == 16'hFFFF) ? r_timer : r_timer + 16'd1;

    // Command string ROM: length per index and byte at {command, position}
    always_comb begin
        w_len = 4'd0;
        case (r_cmd)
            3'd0:    w_len = 4'd4;
            3'd1:    w_len = 4'd6;
            3'd2:    w_len = 4'd8;
            3'd3:    w_len = 4'd8;
            default: w_len = 4'd0;
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        case ({r_cmd, r_idx})
            6'o00: w_byte = 8'h41;
            6'o01: w_byte = 8'h54;
            6'o02: w_byte = 8'h0D;
            6'o03: w_byte = 8'h0A;
            6'o10: w_byte = 8'h41;
            6'o11: w_byte = 8'h54;
            6'o12: w_byte = 8'h45;
            6'o13: w_byte = 8'h30;
            6'o14: w_byte = 8'h0D;
            6'o15: w_byte = 8'h0A;
            6'o20: w_byte = 8'h41;
            6'o21: w_byte = 8'h54;
            6'o22: w_byte = 8'h2B;
            6'o23: w_byte = 8'h52;
            6'o24: w_byte = 8'h53;
            6'o25: w_byte = 8'h54;
            6'o26: w_byte = 8'h0D;
            6'o27: w_byte = 8'h0A;
            6'o30: w_byte = 8'h41;
            6'o31: w_byte = 8'h54;
            6'o32: w_byte = 8'h2B;
            6'o33: w_byte = 8'h47;
            6'o34: w_byte = 8'h4D;
            6'o35: w_byte = 8'h52;
            6'o36: w_byte = 8'h0D;
            6'o37: w_byte = 8'h0A;
            default: w_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_start_q  <= 1'b0;
            r_cmd      <= 3'd0;
            r_idx      <= 3'd0;
            r_timer    <= 16'd0;
            r_ready    <= 1'b1;
            r_tx_data  <= 8'h00;
            r_tx_start <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_start_q  <= start;
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_cmd   <= command_1;
                        r_idx   <= 3'd0;
                        r_err   <= 1'b0;
                        r_ready <= 1'b0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_len == 4'd0) begin
                        r_err   <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_tx_data  <= w_byte;
                        r_tx_start <= 1'b1;
                        r_timer    <= 16'd0;
                        r_state    <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (tx_busy) begin
                        r_state <= S_WAIT_LO;
                    end else begin
                        r_timer <= w_timer_inc;
                        if (w_timer_inc >= BUSY_TIMEOUT) begin
                            r_err   <= 1'b1;
                            r_state <= S_FINISH;
                        end
                    end
                end
                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        r_timer <= 16'd0;
                        // A zero gap advances straight to the next byte
                        if (GAP_CYCLES != 16'd0) begin
                            r_state <= S_GAP;
                        end else if (w_last) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_GAP: begin
                    r_timer <= w_timer_inc;
                    if (w_timer_inc >= GAP_CYCLES) begin
                        if (w_last) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_FINISH: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_cmd      <= 3'd0;
                    r_idx      <= 3'd0;
                    r_timer    <= 16'd0;
                    r_ready    <= 1'b1;
                    r_tx_data  <= 8'h00;
                    r_tx_start <= 1'b0;
                    r_err      <= 1'b0;
                end
            endcase
        end
    end

    assign ready_command = r_ready;
    assign tx_data       = r_tx_data;
    assign tx_start      = r_tx_start;
    assign cmd_err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_command_sender.sv
// ============================================================================
// Module  : tb_command_sender
// Brief   : Randomised scoreboard bench for command_sender with a UART model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_command_sender;

    localparam logic [15:0] c_GAP = 16'd4;
    localparam logic [15:0] c_TMO = 16'd20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] command_1 = 3'd0;
    logic       ready_command;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       cmd_err;
    logic       model_busy = 1'b0;
    logic       poke_busy = 1'b0;

    int  vectors = 0;
    int  errors = 0;
    int  cyc = 0;
    int  tx_seen = 0;
    int  launch_cyc = 0;
    int  first_tx_cyc = -1;
    bit  want_first = 1'b0;
    bit  stuck = 1'b0;
    int  busy_len = 10;

    logic [7:0] exp_q[$];
    string rom[4] = '{"AT\r\n", "ATE0\r\n", "AT+RST\r\n", "AT+GMR\r\n"};

    assign tx_busy = model_busy | poke_busy;

    command_sender #(
        .GAP_CYCLES   (c_GAP),
        .BUSY_TIMEOUT (c_TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .command_1     (command_1),
        .ready_command (ready_command),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .tx_busy       (tx_busy),
        .cmd_err       (cmd_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // UART transmitter: busy rises a few clocks after tx_start, then falls
    always begin
        @(negedge clk);
        if (rst && tx_start && !stuck) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            model_busy = 1'b1;
            repeat (busy_len) @(negedge clk);
            model_busy = 1'b0;
        end
    end

    // Monitor: every tx_start pulse consumes one expected byte
    always @(negedge clk) begin
        if (rst && tx_start) begin
            tx_seen++;
            if (want_first) begin
                first_tx_cyc = cyc;
                want_first   = 1'b0;
            end
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL extra_tx: got byte %0h, required no tx_start", tx_data);
            end else begin
                check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic run_cmd(input logic [2:0] cmd, input bit stk, input int blen);
        int n_exp;
        bit exp_err;
        int low;
        stuck    = stk;
        busy_len = blen;
        n_exp    = (cmd < 3'd4) ? (stk ? 1 : rom[cmd].len()) : 0;
        exp_err  = (cmd >= 3'd4) || stk;
        for (int i = 0; i < n_exp; i++) exp_q.push_back(rom[cmd][i]);
        @(negedge clk);
        command_1    = cmd;
        start        = 1'b1;
        launch_cyc   = cyc;
        first_tx_cyc = -1;
        want_first   = 1'b1;
        @(negedge clk);
        check("ready_fall", {31'd0, ready_command}, 32'd0);
        check("err_cleared_on_launch", {31'd0, cmd_err}, 32'd0);
        command_1 = 3'($urandom);
        low = 1;
        while (ready_command == 1'b0 && low < 5000) begin
            @(negedge clk);
            if (ready_command == 1'b0) begin
                low++;
                if (low == 3) start = 1'b0;
                if (low == 5) start = 1'b1;
            end
        end
        if (low >= 5000) begin
            vectors++;
            errors++;
            $display("FAIL ready_timeout: ready_command still 0 after %0d clks, required 1", low);
        end
        check("cmd_err", {31'd0, cmd_err}, {31'd0, exp_err});
        check("bytes_outstanding", exp_q.size(), 32'd0);
        if (cmd >= 3'd4)
            check("invalid_ready_low_clks", low, 32'd2);
        else if (stk)
            check("timeout_window", {31'd0, (low >= 20 && low <= 24)}, 32'd1);
        else
            check("first_tx_latency", first_tx_cyc - launch_cyc, 32'd2);
        start      = 1'b0;
        stuck      = 1'b0;
        want_first = 1'b0;
        repeat ($urandom_range(2, 6)) @(negedge clk);
    endtask

    initial begin
        int base;
        int total;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, ready_command}, 32'd1);
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        rst = 1'b1;

        // Idle with tx_busy wiggling must never produce a pulse
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            poke_busy = ~poke_busy;
        end
        poke_busy = 1'b0;
        @(negedge clk);
        check("idle_no_tx", tx_seen, 32'd0);
        check("idle_ready", {31'd0, ready_command}, 32'd1);

        run_cmd(3'd0, 1'b0, 10);

        base  = tx_seen;
        total = 0;
        for (int c = 0; c < 4; c++) begin
            run_cmd(3'(c), 1'b0, $urandom_range(1, 8));
            total += rom[c].len();
        end
        check("sequence_byte_count", tx_seen - base, total);

        run_cmd(3'd5, 1'b0, 5);
        run_cmd(3'd0, 1'b0, 3);
        run_cmd(3'd1, 1'b1, 0);

        // Asynchronous reset in the middle of cmd 2
        for (int i = 0; i < 8; i++) exp_q.push_back(rom[2][i]);
        busy_len = 4;
        base = tx_seen;
        @(negedge clk);
        command_1 = 3'd2;
        start     = 1'b1;
        for (int i = 0; i < 2000 && (tx_seen - base) < 3; i++) @(negedge clk);
        check("mid_reset_reached_byte3", {31'd0, ((tx_seen - base) >= 3)}, 32'd1);
        @(posedge clk);
        #2;
        rst   = 1'b0;
        start = 1'b0;
        #1;
        check("arst_ready", {31'd0, ready_command}, 32'd1);
        check("arst_tx_start", {31'd0, tx_start}, 32'd0);
        check("arst_tx_data", {24'd0, tx_data}, 32'd0);
        check("arst_cmd_err", {31'd0, cmd_err}, 32'd0);
        exp_q.delete();
        repeat (30) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        run_cmd(3'd2, 1'b0, 5);

        for (int n = 0; n < 20; n++) begin
            run_cmd(3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0), $urandom_range(1, 12));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
